butterfly_result_collector: RTL and testbench



---
 rtl/fft_pkg.sv | 21 ++
 rtl/frame_fifo.sv | 60 ++++++
 rtl/butterfly_result_collector.sv | 129 ++++++++++++
 tb/tb_butterfly_result_collector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT butterfly result path.
package fft_pkg;

    localparam int unsigned WORD_W = 8;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t re_y;
        word_t im_y;
        word_t re_z;
        word_t im_z;
    } frame_t;

    // Position of each result word within the serial group.
    localparam logic [1:0] IDX_REY = 2'd0;
    localparam logic [1:0] IDX_IMY = 2'd1;
    localparam logic [1:0] IDX_REZ = 2'd2;
    localparam logic [1:0] IDX_IMZ = 2'd3;

endpackage

// File: rtl/frame_fifo.sv
// Generic frame FIFO with first-word-fall-through head and occupancy count.
module frame_fifo #(
    parameter int unsigned FW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [FW-1:0]            push_data,
    input  logic                     pop,
    output logic [FW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [FW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    count_q;
    logic           full;
    logic           pop_ok;
    logic           push_ok;

    // Push is allowed into a full FIFO only when the head leaves on the same edge.
    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        push_ok = push && (!full || pop_ok);
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/butterfly_result_collector.sv
// Gathers serial butterfly results (ReY, ImY, ReZ, ImZ) into frames and
// buffers them for a valid/ready consumer.
module butterfly_result_collector
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_re_y,
    output logic [WIDTH-1:0]         out_im_y,
    output logic [WIDTH-1:0]         out_re_z,
    output logic [WIDTH-1:0]         out_im_z,
    output logic [$clog2(DEPTH):0]   frame_count,
    output logic [1:0]               word_idx,
    output logic                     overflow
);

    localparam int unsigned FW = 4 * WIDTH;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [WIDTH-1:0] slot2_q, slot2_d;
    logic             overflow_q, overflow_d;

    logic             accept_word;
    logic             last_word;
    logic             pop;
    logic             full;
    logic             drop;
    logic [FW-1:0]    push_frame;
    logic [FW-1:0]    head;
    logic [CW-1:0]    count;

    // Handshake and push/drop decisions; clear suppresses the incoming word.
    always_comb begin
        accept_word = in_valid && !clear;
        last_word   = accept_word && (idx_q == IDX_IMZ);
        out_valid   = (count != '0);
        pop         = out_valid && out_ready;
        full        = (count == CW'(DEPTH));
        drop        = last_word && full && !pop;
        push_frame  = {slot0_q, slot1_q, slot2_q, in_data};
    end

    // Assembly slots, word index and sticky overflow next-state.
    always_comb begin
        idx_d      = idx_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        slot2_d    = slot2_q;
        overflow_d = overflow_q;
        if (clear) begin
            idx_d      = IDX_REY;
            slot0_d    = '0;
            slot1_d    = '0;
            slot2_d    = '0;
            overflow_d = 1'b0;
        end else if (in_valid) begin
            unique case (idx_q)
                IDX_REY: slot0_d = in_data;
                IDX_IMY: slot1_d = in_data;
                IDX_REZ: slot2_d = in_data;
                default: ;
            endcase
            idx_d = idx_q + 1'b1;
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Assembly state registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            idx_q      <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            slot2_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            slot2_q    <= slot2_d;
            overflow_q <= overflow_d;
        end
    end

    frame_fifo #(
        .FW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (nReset),
        .push      (last_word),
        .push_data (push_frame),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Head frame is exposed only while valid.
    always_comb begin
        out_re_y = '0;
        out_im_y = '0;
        out_re_z = '0;
        out_im_z = '0;
        if (out_valid) begin
            out_re_y = head[FW-1 -: WIDTH];
            out_im_y = head[FW-WIDTH-1 -: WIDTH];
            out_re_z = head[2*WIDTH-1 -: WIDTH];
            out_im_z = head[WIDTH-1 -: WIDTH];
        end
    end

    assign frame_count = count;
    assign word_idx    = idx_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_butterfly_result_collector.sv
// Self-checking bench for butterfly_result_collector using a frame scoreboard.
module tb_butterfly_result_collector;
    import fft_pkg::*;

    logic       Clock;
    logic       nReset;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_re_y, out_im_y, out_re_z, out_im_z;
    logic [2:0] frame_count;
    logic [1:0] word_idx;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    frame_t q[$];

    butterfly_result_collector #(.WIDTH(8), .DEPTH(4)) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re_y    (out_re_y),
        .out_im_y    (out_im_y),
        .out_re_z    (out_re_z),
        .out_im_z    (out_im_z),
        .frame_count (frame_count),
        .word_idx    (word_idx),
        .overflow    (overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic frame_t mk(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d);
        frame_t f;
        f.re_y = a; f.im_y = b; f.re_z = c; f.im_z = d;
        return f;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_status(input string name, input logic [2:0] cnt,
                                input logic [1:0] idx, input logic ovf);
        total++;
        if ({frame_count, word_idx, overflow} !== {cnt, idx, ovf}) begin
            bad++;
            $display("FAIL %s: count/idx/ovf got %0d/%0d/%0b want %0d/%0d/%0b",
                     name, frame_count, word_idx, overflow, cnt, idx, ovf);
        end
    endtask

    // Pops every frame held in the scoreboard and compares in order.
    task automatic drain(input string name);
        frame_t got;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            if (out_valid === 1'b1) begin
                got = mk(out_re_y, out_im_y, out_re_z, out_im_z);
                total++;
                if (got !== q[0]) begin
                    bad++;
                    $display("FAIL %s frame: got %h want %h", name, got, q[0]);
                end
                void'(q.pop_front());
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: %0d frames never appeared", name, q.size());
            q.delete();
        end
        total++;
        if ({out_valid, frame_count, out_re_y, out_im_y, out_re_z, out_im_z} !== '0) begin
            bad++;
            $display("FAIL %s empty: valid=%b count=%0d data=%h%h%h%h want all 0",
                     name, out_valid, frame_count, out_re_y, out_im_y, out_re_z, out_im_z);
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        total++;
        if ({out_valid, out_re_y, out_im_y, out_re_z, out_im_z} !== '0) begin
            bad++;
            $display("FAIL reset outputs: got %b/%h%h%h%h want 0", out_valid,
                     out_re_y, out_im_y, out_re_z, out_im_z);
        end
        check_status("reset", 3'd0, 2'd0, 1'b0);
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        send_word(8'h12);
        send_word(8'h34);
        send_word(8'hF0);
        in_valid = 1'b1; in_data = 8'h80;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single early_valid: got %b want 0", out_valid);
        end
        tick();
        in_valid = 1'b0; in_data = '0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL single latency: out_valid got %b want 1", out_valid);
        end
        check_status("single", 3'd1, 2'd0, 1'b0);
        q.push_back(mk(8'h12, 8'h34, 8'hF0, 8'h80));
        drain("single");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int w = 0; w < 4; w++) send_word(8'(f * 4 + w + 1));
            if (f < 4) q.push_back(mk(8'(f*4+1), 8'(f*4+2), 8'(f*4+3), 8'(f*4+4)));
        end
        check_status("full", 3'd4, 2'd0, 1'b1);
        drain("backpressure");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_status("clear_ovf", 3'd0, 2'd0, 1'b0);
    endtask

    task automatic test_push_pop_full();
        frame_t got;
        out_ready = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 4; w++) send_word(8'h40 + 8'(f * 4 + w));
            q.push_back(mk(8'h40+8'(f*4), 8'h41+8'(f*4), 8'h42+8'(f*4), 8'h43+8'(f*4)));
        end
        send_word(8'hC1);
        send_word(8'hC2);
        send_word(8'hC3);
        in_valid = 1'b1; in_data = 8'hC4; out_ready = 1'b1;
        got = mk(out_re_y, out_im_y, out_re_z, out_im_z);
        total++;
        if (got !== q[0]) begin
            bad++;
            $display("FAIL pushpop head: got %h want %h", got, q[0]);
        end
        void'(q.pop_front());
        q.push_back(mk(8'hC1, 8'hC2, 8'hC3, 8'hC4));
        tick();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        check_status("pushpop", 3'd4, 2'd0, 1'b0);
        drain("pushpop");
    endtask

    task automatic test_clear();
        send_word(8'hAA);
        send_word(8'hBB);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_data = '0;
        check_status("clear_mid", 3'd0, 2'd0, 1'b0);
        for (int w = 1; w <= 4; w++) send_word(8'(w));
        q.push_back(mk(8'h01, 8'h02, 8'h03, 8'h04));
        drain("clear");
    endtask

    task automatic test_gapped();
        logic [7:0] words [4];
        words[0] = 8'h7F; words[1] = 8'h80; words[2] = 8'h00; words[3] = 8'hFF;
        for (int w = 0; w < 4; w++) begin
            total++;
            if (word_idx !== 2'(w)) begin
                bad++;
                $display("FAIL gapped idx: got %0d want %0d", word_idx, w);
            end
            send_word(words[w]);
            repeat (2) tick();
        end
        check_status("gapped", 3'd1, 2'd0, 1'b0);
        q.push_back(mk(8'h7F, 8'h80, 8'h00, 8'hFF));
        drain("gapped");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int w = 0; w < 4; w++) send_word(8'h90 + 8'(f * 4 + w));
        send_word(8'hE1);
        send_word(8'hE2);
        check_status("pre_reset", 3'd2, 2'd2, 1'b0);
        #2;
        nReset = 1'b0;
        #1;
        total++;
        if ({out_valid, frame_count, word_idx, overflow,
             out_re_y, out_im_y, out_re_z, out_im_z} !== '0) begin
            bad++;
            $display("FAIL async_reset: valid=%b count=%0d idx=%0d ovf=%b data=%h%h%h%h want all 0",
                     out_valid, frame_count, word_idx, overflow,
                     out_re_y, out_im_y, out_re_z, out_im_z);
        end
        tick();
        nReset = 1'b1;
        tick();
        check_status("post_reset", 3'd0, 2'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_push_pop_full();
        test_clear();
        test_gapped();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
